// File: rtl/fetch_pkg.sv
// Shared types and helpers for the instruction fetch queue.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package fetch_pkg;

  localparam int XLEN = 32;

  typedef struct packed {
    logic [XLEN-1:0] instr;
    logic [XLEN-1:0] pc;
  } fetch_entry_t;

  // Number of entries decode consumes in a cycle (0..2).
  typedef logic [1:0] take_t;

  // Advance a queue pointer by inc, wrapping at depth.
  // Depth is a power of two, so the wrap is a mask.
  function automatic logic [31:0] ptr_add(input logic [31:0] ptr,
                                          input logic [31:0] inc,
                                          input logic [31:0] depth);
    return (ptr + inc) & (depth - 32'd1);
  endfunction

endpackage

// File: rtl/fetch_queue.sv
// Dual-entry instruction fetch buffer between the I-cache and decode.
// Latency: a pushed pair is visible at the outputs one cycle later; head reads are zero-latency.
// Backpressure: in_ready drops once fewer than two entries are free; pushes made then are dropped.
//
// Ports:
//   clk, reset          clock (rising edge), asynchronous active-low reset
//   in_valid_1/2        slot valids; slot 2 is honoured only together with slot 1
//   in_instr_1/2        slot instructions (slot 1 is older)
//   in_pc_1/2           slot pcs
//   in_ready            a full pair can be accepted this cycle
//   out_valid_1/2       head / head+1 entry present
//   out_instr_1/2       head / head+1 instruction (0 when not valid)
//   out_pc_1/2          head / head+1 pc (0 when not valid)
//   out_take            entries decode consumes this cycle (0..2)
//   flush               discard contents and any same-cycle push/pop
//   count               occupied entries
module fetch_queue
  import fetch_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    in_valid_1,
  input  logic                    in_valid_2,
  input  logic [XLEN-1:0]         in_instr_1,
  input  logic [XLEN-1:0]         in_instr_2,
  input  logic [XLEN-1:0]         in_pc_1,
  input  logic [XLEN-1:0]         in_pc_2,
  output logic                    in_ready,
  output logic                    out_valid_1,
  output logic                    out_valid_2,
  output logic [XLEN-1:0]         out_instr_1,
  output logic [XLEN-1:0]         out_instr_2,
  output logic [XLEN-1:0]         out_pc_1,
  output logic [XLEN-1:0]         out_pc_2,
  input  take_t                   out_take,
  input  logic                    flush,
  output logic [$clog2(DEPTH):0]  count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  fetch_entry_t mem [DEPTH];
  logic [PW-1:0] head;
  logic [PW-1:0] tail;

  logic          push_1;
  logic          push_2;
  logic [1:0]    pushes;
  logic [1:0]    take_lim;
  logic [1:0]    pops;
  logic [PW-1:0] head_p1;
  logic [PW-1:0] tail_p1;
  logic [PW-1:0] head_next;
  logic [PW-1:0] tail_next;
  logic [CW-1:0] count_next;
  fetch_entry_t  entry_1;
  fetch_entry_t  entry_2;

  // Ready comes from registered occupancy only, so a same-cycle pop never
  // opens room for a push; this keeps in_ready off the decode timing path.
  assign in_ready = (count <= CW'(DEPTH - 2));

  always_comb begin
    push_1   = in_ready && in_valid_1 && !flush;
    push_2   = push_1 && in_valid_2;
    pushes   = {1'b0, push_1} + {1'b0, push_2};
    // Take values above two are treated as two, then clamped to occupancy.
    // When count <= take_lim the count fits in two bits, so the slice is exact.
    take_lim = (out_take > 2'd2) ? 2'd2 : out_take;
    pops     = (CW'(take_lim) > count) ? count[1:0] : take_lim;

    head_p1    = PW'(ptr_add(32'(head), 32'd1, 32'(DEPTH)));
    tail_p1    = PW'(ptr_add(32'(tail), 32'd1, 32'(DEPTH)));
    head_next  = PW'(ptr_add(32'(head), 32'(pops), 32'(DEPTH)));
    tail_next  = PW'(ptr_add(32'(tail), 32'(pushes), 32'(DEPTH)));
    count_next = count + CW'(pushes) - CW'(pops);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (flush) begin
      // Flush wins over push and pop in the same cycle.
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (push_1) begin
        mem[tail] <= '{instr: in_instr_1, pc: in_pc_1};
      end
      if (push_2) begin
        mem[tail_p1] <= '{instr: in_instr_2, pc: in_pc_2};
      end
      head  <= head_next;
      tail  <= tail_next;
      count <= count_next;
    end
  end

  // Zero-latency read of the two oldest entries, masked to zero when absent.
  always_comb begin
    entry_1     = mem[head];
    entry_2     = mem[head_p1];
    out_valid_1 = (count >= CW'(1));
    out_valid_2 = (count >= CW'(2));
    out_instr_1 = out_valid_1 ? entry_1.instr : '0;
    out_pc_1    = out_valid_1 ? entry_1.pc    : '0;
    out_instr_2 = out_valid_2 ? entry_2.instr : '0;
    out_pc_2    = out_valid_2 ? entry_2.pc    : '0;
  end

  // Decode asking for more entries than exist is a protocol error; the pop
  // is clamped above so the queue state stays consistent.
  always @(posedge clk) begin
    if (reset && !flush) begin
      assert (CW'(out_take) <= count)
      else $warning("fetch_queue: out_take %0d exceeds count %0d, clamped", out_take, count);
    end
  end

endmodule

// File: tb/tb_fetch_queue.sv
// Directed bench for fetch_queue: reset, pair push, fill/backpressure,
// push+pop across pointer wrap, flush priority, over-take clamp.
module tb_fetch_queue;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid_1, in_valid_2;
  logic [31:0] in_instr_1, in_instr_2, in_pc_1, in_pc_2;
  logic        in_ready;
  logic        out_valid_1, out_valid_2;
  logic [31:0] out_instr_1, out_instr_2, out_pc_1, out_pc_2;
  logic [1:0]  out_take;
  logic        flush;
  logic [3:0]  count;

  int total = 0;
  int bad   = 0;

  fetch_queue #(.DEPTH(8)) dut (
    .clk(clk), .reset(reset),
    .in_valid_1(in_valid_1), .in_valid_2(in_valid_2),
    .in_instr_1(in_instr_1), .in_instr_2(in_instr_2),
    .in_pc_1(in_pc_1), .in_pc_2(in_pc_2),
    .in_ready(in_ready),
    .out_valid_1(out_valid_1), .out_valid_2(out_valid_2),
    .out_instr_1(out_instr_1), .out_instr_2(out_instr_2),
    .out_pc_1(out_pc_1), .out_pc_2(out_pc_2),
    .out_take(out_take), .flush(flush), .count(count)
  );

  always #5 clk = ~clk;

  task automatic idle();
    in_valid_1 = 0; in_valid_2 = 0;
    in_instr_1 = 0; in_instr_2 = 0; in_pc_1 = 0; in_pc_2 = 0;
    out_take = 0; flush = 0;
  endtask

  // Apply one cycle of stimulus, sample 1 time unit after the edge, return to idle.
  task automatic op(input logic v1, input logic v2,
                    input logic [31:0] i1, input logic [31:0] p1,
                    input logic [31:0] i2, input logic [31:0] p2,
                    input logic [1:0] take, input logic fl);
    in_valid_1 = v1; in_valid_2 = v2;
    in_instr_1 = i1; in_pc_1 = p1; in_instr_2 = i2; in_pc_2 = p2;
    out_take = take; flush = fl;
    @(posedge clk); #1;
    idle();
  endtask

  task automatic test_reset();
    op(1, 1, 32'hA1, 32'h40, 32'hA2, 32'h44, 0, 0);
    op(1, 0, 32'hA3, 32'h48, 0, 0, 0, 0);
    total++; if (count !== 4'd3) begin bad++; $display("FAIL rst_pre_count: got %0d want 3", count); end
    #2 reset = 1'b0;
    #1;
    total++; if (count !== 4'd0) begin bad++; $display("FAIL rst_count: got %0d want 0", count); end
    total++; if (out_valid_1 !== 1'b0 || out_valid_2 !== 1'b0) begin bad++; $display("FAIL rst_valid: got %b%b want 00", out_valid_1, out_valid_2); end
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL rst_ready: got %b want 1", in_ready); end
    total++; if (out_instr_1 !== 0 || out_pc_1 !== 0 || out_instr_2 !== 0 || out_pc_2 !== 0) begin
      bad++; $display("FAIL rst_data: got %h %h %h %h want zeros", out_instr_1, out_pc_1, out_instr_2, out_pc_2);
    end
    @(posedge clk); #1 reset = 1'b1;
    @(posedge clk); #1;
    total++; if (count !== 4'd0) begin bad++; $display("FAIL rst_release_count: got %0d want 0", count); end
  endtask

  task automatic test_pair_push();
    in_valid_1 = 1; in_valid_2 = 1;
    in_instr_1 = 32'h11; in_pc_1 = 32'h0; in_instr_2 = 32'h22; in_pc_2 = 32'h4;
    #1;
    total++; if (out_valid_1 !== 1'b0) begin bad++; $display("FAIL pair_latency: got valid %b want 0", out_valid_1); end
    @(posedge clk); #1;
    idle();
    total++; if (count !== 4'd2) begin bad++; $display("FAIL pair_count: got %0d want 2", count); end
    total++; if (out_instr_1 !== 32'h11 || out_instr_2 !== 32'h22) begin
      bad++; $display("FAIL pair_instr: got %h %h want 11 22", out_instr_1, out_instr_2);
    end
    total++; if (out_pc_1 !== 32'h0 || out_pc_2 !== 32'h4) begin
      bad++; $display("FAIL pair_pc: got %h %h want 0 4", out_pc_1, out_pc_2);
    end
    total++; if (out_valid_1 !== 1'b1 || out_valid_2 !== 1'b1) begin bad++; $display("FAIL pair_valid: got %b%b want 11", out_valid_1, out_valid_2); end
    op(0, 0, 0, 0, 0, 0, 0, 1);  // clean slate
  endtask

  task automatic test_fill();
    logic [31:0] exp_i [7];
    for (int k = 0; k < 3; k++) begin
      op(1, 1, 32'h100 + 2*k, 32'h1000 + 8*k, 32'h101 + 2*k, 32'h1004 + 8*k, 0, 0);
    end
    total++; if (count !== 4'd6) begin bad++; $display("FAIL fill_count6: got %0d want 6", count); end
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL fill_ready6: got %b want 1", in_ready); end
    op(1, 0, 32'h106, 32'h1018, 0, 0, 0, 0);
    total++; if (count !== 4'd7) begin bad++; $display("FAIL fill_count7: got %0d want 7", count); end
    total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL fill_ready7: got %b want 0", in_ready); end
    op(1, 1, 32'hDEAD0000, 32'h0, 32'hDEAD0001, 32'h0, 0, 0);
    total++; if (count !== 4'd7) begin bad++; $display("FAIL fill_drop: got %0d want 7", count); end
    for (int k = 0; k < 7; k++) exp_i[k] = 32'h100 + k;
    for (int pos = 0; pos < 7; pos += 2) begin
      total++; if (out_instr_1 !== exp_i[pos] || out_pc_1 !== 32'h1000 + 4*pos) begin
        bad++; $display("FAIL fill_drain1[%0d]: got %h/%h want %h/%h", pos, out_instr_1, out_pc_1, exp_i[pos], 32'h1000 + 4*pos);
      end
      if (pos < 6) begin
        total++; if (out_instr_2 !== exp_i[pos+1]) begin
          bad++; $display("FAIL fill_drain2[%0d]: got %h want %h", pos, out_instr_2, exp_i[pos+1]);
        end
        op(0, 0, 0, 0, 0, 0, 2, 0);
      end else begin
        total++; if (out_valid_2 !== 1'b0 || out_instr_2 !== 32'h0) begin
          bad++; $display("FAIL fill_last: got valid %b instr %h want 0 0", out_valid_2, out_instr_2);
        end
        op(0, 0, 0, 0, 0, 0, 1, 0);
      end
    end
    total++; if (count !== 4'd0) begin bad++; $display("FAIL fill_empty: got %0d want 0", count); end
  endtask

  task automatic test_wrap_push_pop();
    op(0, 0, 0, 0, 0, 0, 0, 1);  // head = tail = 0
    op(1, 1, 32'h201, 32'h2000, 32'h202, 32'h2004, 0, 0);
    op(1, 1, 32'h203, 32'h2008, 32'h204, 32'h200C, 0, 0);
    op(1, 1, 32'h205, 32'h2010, 32'h206, 32'h2014, 0, 0);
    op(1, 0, 32'h207, 32'h2018, 0, 0, 0, 0);
    op(0, 0, 0, 0, 0, 0, 2, 0);
    op(0, 0, 0, 0, 0, 0, 2, 0);
    // head = 4, tail = 7, count = 3
    total++; if (count !== 4'd3 || out_instr_1 !== 32'h205) begin
      bad++; $display("FAIL wrap_pre: got count %0d head %h want 3 205", count, out_instr_1);
    end
    op(1, 1, 32'h208, 32'h201C, 32'h209, 32'h2020, 1, 0);  // writes slots 7 and 0
    total++; if (count !== 4'd4) begin bad++; $display("FAIL wrap_count: got %0d want 4", count); end
    total++; if (out_instr_1 !== 32'h206 || out_instr_2 !== 32'h207) begin
      bad++; $display("FAIL wrap_head: got %h %h want 206 207", out_instr_1, out_instr_2);
    end
    op(0, 0, 0, 0, 0, 0, 2, 0);
    total++; if (out_instr_1 !== 32'h208 || out_instr_2 !== 32'h209 || out_pc_2 !== 32'h2020) begin
      bad++; $display("FAIL wrap_straddle: got %h %h pc %h want 208 209 2020", out_instr_1, out_instr_2, out_pc_2);
    end
    op(0, 0, 0, 0, 0, 0, 2, 0);
    total++; if (count !== 4'd0) begin bad++; $display("FAIL wrap_empty: got %0d want 0", count); end
  endtask

  task automatic test_flush();
    op(1, 1, 32'h301, 32'h3000, 32'h302, 32'h3004, 0, 0);
    op(1, 1, 32'h303, 32'h3008, 32'h304, 32'h300C, 0, 0);
    op(1, 0, 32'h305, 32'h3010, 0, 0, 0, 0);
    total++; if (count !== 4'd5) begin bad++; $display("FAIL flush_pre: got %0d want 5", count); end
    op(1, 1, 32'h3EE, 32'h3F00, 32'h3EF, 32'h3F04, 2, 1);
    total++; if (count !== 4'd0) begin bad++; $display("FAIL flush_count: got %0d want 0", count); end
    total++; if (out_valid_1 !== 1'b0 || out_instr_1 !== 32'h0) begin
      bad++; $display("FAIL flush_valid: got %b %h want 0 0", out_valid_1, out_instr_1);
    end
    op(1, 0, 32'h3AA, 32'h3A00, 0, 0, 0, 0);
    total++; if (count !== 4'd1 || out_instr_1 !== 32'h3AA) begin
      bad++; $display("FAIL flush_after: got count %0d instr %h want 1 3aa", count, out_instr_1);
    end
  endtask

  task automatic test_overtake();
    op(0, 0, 0, 0, 0, 0, 2, 0);  // take 2 with count 1: clamped to 1
    total++; if (count !== 4'd0 || out_valid_1 !== 1'b0) begin
      bad++; $display("FAIL over_clamp: got count %0d valid %b want 0 0", count, out_valid_1);
    end
    op(0, 1, 32'h0, 32'h0, 32'h4CC, 32'h4C00, 0, 0);
    total++; if (count !== 4'd0) begin bad++; $display("FAIL v2_alone: got %0d want 0", count); end
    op(1, 0, 32'h4BB, 32'h4B00, 0, 0, 0, 0);
    total++; if (count !== 4'd1 || out_instr_1 !== 32'h4BB || out_pc_1 !== 32'h4B00) begin
      bad++; $display("FAIL over_after: got %0d %h %h want 1 4bb 4b00", count, out_instr_1, out_pc_1);
    end
    total++; if (out_valid_2 !== 1'b0 || out_instr_2 !== 32'h0) begin
      bad++; $display("FAIL over_slot2: got %b %h want 0 0", out_valid_2, out_instr_2);
    end
  endtask

  initial begin
    reset = 1'b0;
    idle();
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    test_reset();
    test_pair_push();
    test_fill();
    test_wrap_push_pop();
    test_flush();
    test_overtake();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
